// File: rtl/ultrasonic_echo_emulator_if.sv
// Trig/echo link between a ranging controller (master) and the sensor emulator (slave).
// Also carries the programmed target and the emulator status signals.
interface ultrasonic_echo_emulator_if;
    logic       trig;
    logic [9:0] distance_cm;
    logic       no_target;
    logic       echo;
    logic       busy;
    logic [2:0] state_out;
    logic       trig_reject;

    modport master (
        output trig,
        output distance_cm,
        output no_target,
        input  echo,
        input  busy,
        input  state_out,
        input  trig_reject
    );

    modport slave (
        input  trig,
        input  distance_cm,
        input  no_target,
        output echo,
        output busy,
        output state_out,
        output trig_reject
    );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// Sensor side of an HC-SR04 style trig/echo link: validates the trig pulse, waits out the
// burst, then answers with an echo whose width encodes the programmed distance.
module ultrasonic_echo_emulator #(
    parameter int unsigned TRIG_MIN_CYCLES = 1000,
    parameter int unsigned BURST_CYCLES    = 20000,
    parameter int unsigned CYCLES_PER_CM   = 5883,
    parameter int unsigned MIN_CM          = 2,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned TIMEOUT_CYCLES  = 3800000,
    parameter int unsigned HOLDOFF_CYCLES  = 1000000
) (
    input logic                       clk,
    input logic                       rst,
    ultrasonic_echo_emulator_if.slave bus
);

    localparam int unsigned LenW   = 23;
    localparam int unsigned MaxA   = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES
                                                                       : HOLDOFF_CYCLES;
    localparam int unsigned MaxB   = (BURST_CYCLES > TRIG_MIN_CYCLES) ? BURST_CYCLES
                                                                      : TRIG_MIN_CYCLES;
    localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = ($clog2(MaxCnt + 1) > LenW) ? $clog2(MaxCnt + 1) : LenW;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StTrigHigh = 3'd1,
        StBurst    = 3'd2,
        StEchoHigh = 3'd3,
        StHoldoff  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              trig_meta_q, trig_meta_d;
    logic              trig_s_q, trig_s_d;
    logic              trig_dly_q, trig_dly_d;
    logic [1:0]        sync_vld_q, sync_vld_d;
    logic              armed_q, armed_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LenW-1:0]   echo_len_q, echo_len_d;
    logic              echo_q, echo_d;
    logic              trig_reject_q, trig_reject_d;
    logic              trig_rise;
    logic [LenW-1:0]   dist_eff;
    logic [LenW-1:0]   echo_len_calc;

    // Edge detection is armed only once the synchroniser has filled and shown trig low, so a
    // level already high at reset release is never taken as a trigger.
    always_comb begin
        trig_meta_d = bus.trig;
        trig_s_d    = trig_meta_q;
        trig_dly_d  = trig_s_q;
        sync_vld_d  = {sync_vld_q[0], 1'b1};
        armed_d     = armed_q | (sync_vld_q[1] & ~trig_s_q);
    end

    assign trig_rise = armed_q & trig_s_q & ~trig_dly_q;

    always_comb begin
        dist_eff = LenW'(bus.distance_cm);
        if (bus.distance_cm < 10'(MIN_CM)) begin
            dist_eff = LenW'(MIN_CM);
        end
        if (bus.no_target || (bus.distance_cm > 10'(MAX_CM))) begin
            echo_len_calc = LenW'(TIMEOUT_CYCLES);
        end else begin
            echo_len_calc = dist_eff * LenW'(CYCLES_PER_CM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        echo_len_d    = echo_len_q;
        echo_d        = 1'b0;
        trig_reject_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (trig_rise) begin
                    state_d = StTrigHigh;
                    cnt_d   = CntW'(1);
                end
            end
            StTrigHigh: begin
                if (trig_s_q) begin
                    if (cnt_q < CntW'(TRIG_MIN_CYCLES)) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (cnt_q >= CntW'(TRIG_MIN_CYCLES)) begin
                    echo_len_d = echo_len_calc;
                    state_d    = StBurst;
                    cnt_d      = CntW'(1);
                end else begin
                    trig_reject_d = 1'b1;
                    state_d       = StIdle;
                    cnt_d         = '0;
                end
            end
            StBurst: begin
                trig_reject_d = trig_rise;
                if (cnt_q == CntW'(BURST_CYCLES)) begin
                    state_d = StEchoHigh;
                    cnt_d   = CntW'(1);
                    echo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StEchoHigh: begin
                trig_reject_d = trig_rise;
                // cnt_q numbers the echo-high cycle currently on the pin
                if (cnt_q == CntW'(echo_len_q)) begin
                    state_d = StHoldoff;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d  = cnt_q + CntW'(1);
                    echo_d = 1'b1;
                end
            end
            StHoldoff: begin
                trig_reject_d = trig_rise;
                if (cnt_q == CntW'(HOLDOFF_CYCLES)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.echo        = echo_q;
        bus.busy        = (state_q != StIdle);
        bus.state_out   = state_q;
        bus.trig_reject = trig_reject_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_meta_q   <= 1'b0;
            trig_s_q      <= 1'b0;
            trig_dly_q    <= 1'b0;
            sync_vld_q    <= 2'b00;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            echo_len_q    <= '0;
            echo_q        <= 1'b0;
            trig_reject_q <= 1'b0;
        end else begin
            trig_meta_q   <= trig_meta_d;
            trig_s_q      <= trig_s_d;
            trig_dly_q    <= trig_dly_d;
            sync_vld_q    <= sync_vld_d;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            echo_len_q    <= echo_len_d;
            echo_q        <= echo_d;
            trig_reject_q <= trig_reject_d;
        end
    end

endmodule
